axil_uart_regs: RTL and testbench
=================================

# axil_uart_regs

AXI4-Lite responder that exposes the UART as four 32-bit memory-mapped registers on the CPU data bus, alongside `data_ram` behind the same `memory_axi` initiator. It buffers received bytes in a small RX FIFO and holds one pending TX byte. The core therefore reaches `uart_transmitter` and `uart_receiver` through ordinary loads and stores.

## Interface
- `RX_FIFO_DEPTH`, 8, RX FIFO entries; power of two, ≥2
- `ADDR_WIDTH`, 16, AXI address width; only bits [3:2] are decoded, so upper bits alias
- `i_Clock` in 1: the single clock
- `i_Reset` in 1: synchronous, active-high reset
- `s_axil_araddr` in ADDR_WIDTH, `s_axil_arvalid` in 1, `s_axil_arready` out 1: read-address channel
- `s_axil_rdata` out 32, `s_axil_rresp` out 2, `s_axil_rvalid` out 1, `s_axil_rready` in 1: read-data channel
- `s_axil_awaddr` in ADDR_WIDTH, `s_axil_awvalid` in 1, `s_axil_awready` out 1: write-address channel
- `s_axil_wdata` in 32, `s_axil_wstrb` in 4, `s_axil_wvalid` in 1, `s_axil_wready` out 1: write-data channel
- `s_axil_bresp` out 2, `s_axil_bvalid` out 1, `s_axil_bready` in 1: write-response channel
- `o_Tx_Data` out 8, `o_Tx_Valid` out 1, `i_Tx_Ready` in 1: byte stream to the transmitter
- `i_Rx_Data` in 8, `i_Rx_Valid` in 1: single-cycle byte strobe from the receiver; there is no backpressure
- `o_Irq` out 1: interrupt; present only with `AXIL_UART_IRQ_EN`

## Operation
- Register map:
  - 0x0 TXDATA
    - Write: byte `wdata[7:0]` loads the TX holding register. Only used if `wstrb[0]`=1; otherwise the write completes OKAY with no effect.
    - Read: returns 0.
  - 0x4 RXDATA
    - Read when FIFO non-empty: pops the head and returns `{24'h0, byte}`.
    - Read when FIFO empty: returns 0x8000_0000, no pop.
    - Write: ignored, OKAY.
  - 0x8 STATUS (read): bit0 tx_full, bit1 rx_nonempty, bit2 rx_full, bit3 rx_overrun (sticky). Writing 1 to bit3 clears it; other bits are read-only.
  - 0xC CONTROL (R/W): bit0 rx_irq_en, bit1 tx_empty_irq_en.
- TX holding register:
  - `o_Tx_Valid` equals tx_full.
  - When `o_Tx_Valid`&`i_Tx_Ready`, the register clears.
  - A TXDATA write while full and not draining in the same cycle drops the byte and returns BRESP=2'b10 (SLVERR).
  - A TXDATA write while draining in the same cycle succeeds with OKAY.
- RX FIFO:
  - `i_Rx_Valid` pushes. A push when full drops the byte and sets rx_overrun.
  - Simultaneous push and pop when full: both succeed, no overrun.
  - Simultaneous push and pop when empty: the read returns empty (0x8000_0000) and the byte is stored.
- Read and write channels are independent; both may complete in the same cycle.
  - Read of STATUS concurrent with a W1C write returns the pre-clear value.
- RRESP is always OKAY.

## Timing
- Reset values: `rvalid` 0, `bvalid` 0, `rdata` 0, `rresp` 0, `bresp` 0, `o_Tx_Valid` 0, `o_Tx_Data` 0, `o_Irq` 0. FIFO empty, overrun 0, CONTROL 0.
- Read channel:
  - `s_axil_arready` = ~rvalid (combinational).
  - AR accepted at edge N: data is sampled and the pop is performed at edge N, and `rvalid` is asserted from N+1.
  - `rvalid` is held with stable `rdata` until `rready`, and deasserts the edge after the handshake.
- Write channel:
  - `awready` = `wready` = `awvalid` & `wvalid` & ~bvalid (combinational). AW and W are only accepted together.
  - Register update happens at the accept edge N; `bvalid` is asserted from N+1 and held until `bready`.
- `i_Rx_Valid` at edge N makes rx_nonempty visible in STATUS for an AR accepted at N+1.
- Reset mid-transaction aborts pending R/B responses and discards FIFO and TX contents; no response is issued for the aborted transfer.

## Configuration
- `AXIL_UART_IRQ_EN` defined:
  - `o_Irq` is registered: (rx_irq_en & rx_nonempty) | (tx_empty_irq_en & ~tx_full), updated one cycle after the cause.
  - CONTROL is read/write.
- Undefined:
  - No `o_Irq` port.
  - CONTROL reads 0 and writes are ignored with OKAY.

## Structure
- Package `axil_uart_pkg` holds:
  - register offset localparams (TXDATA/RXDATA/STATUS/CONTROL)
  - STATUS and CONTROL bit indices
  - RESP_OKAY/RESP_SLVERR constants
  - RXDATA empty value 0x8000_0000
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/head) implements the RX FIFO, with pointers one bit wider than log2(DEPTH) for full/empty.

## Test plan
- Write 0x41 to 0x0 with `i_Tx_Ready`=0 -> BRESP OKAY, `o_Tx_Valid`=1, `o_Tx_Data`=0x41. Second write 0x42 -> BRESP SLVERR, data stays 0x41. Raise `i_Tx_Ready` -> `o_Tx_Valid` drops next cycle.
- Strobe 0x55 then 0x66 on RX; read 0x4 three times -> 0x55, 0x66, 0x8000_0000.
- Push 9 bytes with depth 8 -> STATUS=0x0E. Write 0x8 with 0x8 -> STATUS=0x06. First read of 0x4 returns byte 1; byte 9 is lost.
- Hold `rready`=0 for 5 cycles after an AR to 0x8 -> `rvalid` and `rdata` stay stable, `arready`=0 throughout, exactly one response.
- Issue AR to 0x4 and AW/W to 0x0 in the same cycle -> both complete; R at N+1, B at N+1.
- With `AXIL_UART_IRQ_EN`: CONTROL=0x1, strobe RX byte -> `o_Irq`=1 two cycles later; read 0x4 -> `o_Irq`=0 one cycle after the pop.

Source files
------------

// File: rtl/axil_uart_pkg.sv
// axil_uart_pkg: register map, bit positions and response codes
// shared by the AXI4-Lite UART register block and its bench.
package axil_uart_pkg;

  // word index = addr[3:2]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_RX_NE    = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_OVERRUN  = 3;

  localparam int CTL_RX_IRQ  = 0;
  localparam int CTL_TX_IRQ  = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] RX_EMPTY_VAL = 32'h8000_0000;

endpackage

// File: rtl/axil_uart_if.sv
// axil_if: AXI4-Lite bus bundle with master/slave views.
// Channel signals follow the usual AW/W/B/AR/R naming.
interface axil_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata, wstrb,
    output wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata, wstrb,
    input  wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axil_uart_regs_sync_fifo.sv
// sync_fifo: single-clock FIFO, pointers carry one extra wrap
// bit so full and empty are distinguished without a counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= data;
  end

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];
endmodule

// File: rtl/axil_uart_regs.sv
// axil_uart_regs: AXI4-Lite UART register block (TX hold, RX FIFO).
// Build option AXIL_UART_IRQ_EN adds CONTROL storage and o_Irq.
module axil_uart_regs
  import axil_uart_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH    = 16
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  axil_if.slave      s_axil,
  output logic [7:0] o_Tx_Data,
  output logic       o_Tx_Valid,
  input  logic       i_Tx_Ready,
  input  logic [7:0] i_Rx_Data,
  input  logic       i_Rx_Valid
`ifdef AXIL_UART_IRQ_EN
  ,
  output logic       o_Irq
`endif
);
  if (ADDR_WIDTH < 4) begin : g_bad_aw
    $error("ADDR_WIDTH must cover addr[3:2]");
  end

  logic [1:0]  rsel, wsel;
  logic        ar_fire, r_fire, wr_fire, b_fire;
  logic        tx_full, tx_drain, tx_wr, tx_err;
  logic [7:0]  tx_data;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_head;
  logic        overrun, ovr_clr;
  logic [31:0] status, rd_val, rdata;
  logic        rvalid, bvalid;
  logic [1:0]  bresp;
  logic [1:0]  ctrl;

  assign rsel     = s_axil.araddr[3:2];
  assign wsel     = s_axil.awaddr[3:2];
  assign ar_fire  = s_axil.arvalid & ~rvalid;
  assign r_fire   = rvalid & s_axil.rready;
  assign wr_fire  = s_axil.awvalid & s_axil.wvalid & ~bvalid;
  assign b_fire   = bvalid & s_axil.bready;
  assign tx_drain = tx_full & i_Tx_Ready;

  assign s_axil.arready = ~rvalid;
  assign s_axil.awready = wr_fire;
  assign s_axil.wready  = wr_fire;
  assign s_axil.rvalid  = rvalid;
  assign s_axil.rdata   = rdata;
  assign s_axil.rresp   = RESP_OKAY;
  assign s_axil.bvalid  = bvalid;
  assign s_axil.bresp   = bresp;
  assign o_Tx_Valid     = tx_full;
  assign o_Tx_Data      = tx_data;

  assign tx_wr   = wr_fire & (wsel == REG_TXDATA) & s_axil.wstrb[0];
  assign tx_err  = tx_wr & tx_full & ~tx_drain;
  assign ovr_clr = wr_fire & (wsel == REG_STATUS) &
                   s_axil.wstrb[0] & s_axil.wdata[ST_OVERRUN];

  // a pop frees the slot the same cycle, so push-on-full may proceed
  assign rx_pop  = ar_fire & (rsel == REG_RXDATA) & ~rx_empty;
  assign rx_push = i_Rx_Valid & (~rx_full | rx_pop);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (i_Clock),
    .rst   (i_Reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .data  (i_Rx_Data),
    .full  (rx_full),
    .empty (rx_empty),
    .head  (rx_head)
  );

  always_comb begin
    status = '0;
    status[ST_TX_FULL] = tx_full;
    status[ST_RX_NE]   = ~rx_empty;
    status[ST_RX_FULL] = rx_full;
    status[ST_OVERRUN] = overrun;
  end

  always_comb begin
    rd_val = '0;
    unique case (rsel)
      REG_TXDATA:  rd_val = '0;
      REG_RXDATA:  rd_val = rx_empty ? RX_EMPTY_VAL
                                     : {24'h0, rx_head};
      REG_STATUS:  rd_val = status;
      REG_CONTROL: rd_val = {30'h0, ctrl};
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rvalid  <= 1'b0;
      rdata   <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      tx_full <= 1'b0;
      tx_data <= '0;
      overrun <= 1'b0;
    end else begin
      if (ar_fire) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
      end else if (r_fire) begin
        rvalid <= 1'b0;
      end
      if (wr_fire) begin
        bvalid <= 1'b1;
        bresp  <= tx_err ? RESP_SLVERR : RESP_OKAY;
      end else if (b_fire) begin
        bvalid <= 1'b0;
      end
      if (tx_wr && !tx_err) begin
        tx_full <= 1'b1;
        tx_data <= s_axil.wdata[7:0];
      end else if (tx_drain) begin
        tx_full <= 1'b0;
      end
      // a fresh overrun wins over a same-cycle clear
      if (i_Rx_Valid && rx_full && !rx_pop)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

`ifdef AXIL_UART_IRQ_EN
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      ctrl  <= '0;
      o_Irq <= 1'b0;
    end else begin
      if (wr_fire && wsel == REG_CONTROL && s_axil.wstrb[0])
        ctrl <= s_axil.wdata[1:0];
      o_Irq <= (ctrl[CTL_RX_IRQ] & ~rx_empty) |
               (ctrl[CTL_TX_IRQ] & ~tx_full);
    end
  end
`else
  assign ctrl = 2'b00;
`endif

endmodule

// File: tb/tb_axil_uart_regs.sv
// tb_axil_uart_regs: directed vectors, R/B responses checked by a
// scoreboard monitor against queued hand-computed expectations.
module tb_axil_uart_regs;
  import axil_uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_if #(.ADDR_WIDTH(16)) bus();

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
`ifdef AXIL_UART_IRQ_EN
  logic       irq;
`endif

  axil_uart_regs #(
    .RX_FIFO_DEPTH (8),
    .ADDR_WIDTH    (16)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .s_axil     (bus),
    .o_Tx_Data  (tx_data),
    .o_Tx_Valid (tx_valid),
    .i_Tx_Ready (tx_ready),
    .i_Rx_Data  (rx_data),
    .i_Rx_Valid (rx_valid)
`ifdef AXIL_UART_IRQ_EN
    ,
    .o_Irq      (irq)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int r_seen = 0;
  int b_seen = 0;
  logic [31:0] exp_r[$];
  logic [1:0]  exp_b[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out", name);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rvalid && bus.rready) begin
        r_seen++;
        if (exp_r.size() == 0) timeout("r_unexpected");
        else chk("rdata", bus.rdata, exp_r.pop_front());
        chk("rresp", {30'h0, bus.rresp}, {30'h0, RESP_OKAY});
      end
      if (bus.bvalid && bus.bready) begin
        b_seen++;
        if (exp_b.size() == 0) timeout("b_unexpected");
        else chk("bresp", {30'h0, bus.bresp},
                 {30'h0, exp_b.pop_front()});
      end
    end
  end

  task automatic wait_r();
    int n = 0;
    while (!(bus.rvalid && bus.rready)) begin
      @(negedge clk);
      n++;
      if (n > 50) begin timeout("wait_r"); return; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_b();
    int n = 0;
    while (!(bus.bvalid && bus.bready)) begin
      @(negedge clk);
      n++;
      if (n > 50) begin timeout("wait_b"); return; end
    end
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] e);
    int n = 0;
    exp_r.push_back(e);
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    do begin @(negedge clk); n++; end
    while (!bus.arready && n < 50);
    if (!bus.arready) timeout("arready");
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    wait_r();
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] e);
    int n = 0;
    exp_b.push_back(e);
    bus.awaddr  = a;
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    do begin @(negedge clk); n++; end
    while (!bus.awready && n < 50);
    if (!bus.awready) timeout("awready");
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    wait_b();
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;
    bus.araddr = '0; bus.arvalid = 0; bus.rready = 1;
    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0;
    bus.wstrb = '0;  bus.wvalid = 0;  bus.bready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", {31'h0, bus.rvalid}, 0);
    chk("rst_bvalid", {31'h0, bus.bvalid}, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_txvalid", {31'h0, tx_valid}, 0);
    chk("rst_txdata", {24'h0, tx_data}, 0);
    chk("rst_arready", {31'h0, bus.arready}, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // TX holding register
    wr(16'h0, 32'h41, 4'h1, RESP_OKAY);
    chk("tx_valid_set", {31'h0, tx_valid}, 1);
    chk("tx_data_41", {24'h0, tx_data}, 32'h41);
    rd(16'h8, 32'h1);
    rd(16'h0, 32'h0);
    wr(16'h0, 32'h42, 4'h1, RESP_SLVERR);
    chk("tx_keep_41", {24'h0, tx_data}, 32'h41);
    wr(16'h0, 32'h43, 4'h2, RESP_OKAY);
    chk("tx_nostrb", {24'h0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    chk("tx_drained", {31'h0, tx_valid}, 0);

    // RX FIFO ordering
    strobe(8'h55);
    strobe(8'h66);
    rd(16'h4, 32'h55);
    rd(16'h4, 32'h66);
    rd(16'h4, RX_EMPTY_VAL);

    // overflow, sticky overrun, W1C
    for (int i = 1; i <= 9; i++) strobe(8'(i));
    rd(16'h8, 32'h0E);
    wr(16'h8, 32'h8, 4'h1, RESP_OKAY);
    rd(16'h8, 32'h06);
    for (int i = 1; i <= 8; i++) rd(16'h4, 32'(i));
    rd(16'h4, RX_EMPTY_VAL);
    rd(16'h1008, 32'h0);

    // R held under rready backpressure
    strobe(8'h5A);
    r0 = r_seen;
    bus.rready = 1'b0;
    exp_r.push_back(32'h2);
    bus.araddr = 16'h8;
    bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rvalid", {31'h0, bus.rvalid}, 1);
      chk("hold_rdata", bus.rdata, 32'h2);
      chk("hold_arready", {31'h0, bus.arready}, 0);
    end
    @(posedge clk); #1;
    bus.rready = 1'b1;
    wait_r();
    chk("one_resp", r_seen, r0 + 1);
    rd(16'h4, 32'h5A);

    // concurrent read and write
    strobe(8'h77);
    exp_r.push_back(32'h77);
    exp_b.push_back(RESP_OKAY);
    bus.araddr = 16'h4; bus.arvalid = 1'b1;
    bus.awaddr = 16'h0; bus.wdata = 32'h99; bus.wstrb = 4'h1;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(negedge clk);
    chk("both_ready", {30'h0, bus.arready, bus.awready}, 32'h3);
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("both_valid", {30'h0, bus.rvalid, bus.bvalid}, 32'h3);
    @(posedge clk); #1;
    chk("both_done", {30'h0, bus.rvalid, bus.bvalid}, 32'h0);
    chk("tx_data_99", {24'h0, tx_data}, 32'h99);

    // TXDATA write while draining is accepted
    tx_ready = 1'b1;
    exp_b.push_back(RESP_OKAY);
    bus.awaddr = 16'h0; bus.wdata = 32'hAA; bus.wstrb = 4'h1;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tx_ready = 1'b0;
    chk("drain_wr_valid", {31'h0, tx_valid}, 1);
    chk("drain_wr_data", {24'h0, tx_data}, 32'hAA);
    wait_b();
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;

    // push and pop together while empty
    rx_data = 8'h3C; rx_valid = 1'b1;
    exp_r.push_back(RX_EMPTY_VAL);
    bus.araddr = 16'h4; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; bus.arvalid = 1'b0;
    wait_r();
    rd(16'h4, 32'h3C);

    // push and pop together while full
    for (int i = 0; i < 8; i++) strobe(8'(8'h10 + i));
    rx_data = 8'h18; rx_valid = 1'b1;
    exp_r.push_back(32'h10);
    bus.araddr = 16'h4; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; bus.arvalid = 1'b0;
    wait_r();
    rd(16'h8, 32'h06);
    for (int i = 1; i <= 8; i++) rd(16'h4, 32'h10 + 32'(i));

`ifdef AXIL_UART_IRQ_EN
    wr(16'hC, 32'h1, 4'h1, RESP_OKAY);
    rd(16'hC, 32'h1);
    strobe(8'h21);
    chk("irq_early", {31'h0, irq}, 0);
    @(posedge clk); #1;
    chk("irq_rx", {31'h0, irq}, 1);
    rd(16'h4, 32'h21);
    chk("irq_pop", {31'h0, irq}, 0);
    wr(16'hC, 32'h3, 4'h1, RESP_OKAY);
    chk("irq_tx", {31'h0, irq}, 1);
    wr(16'hC, 32'h0, 4'h1, RESP_OKAY);
`else
    wr(16'hC, 32'h3, 4'h1, RESP_OKAY);
    rd(16'hC, 32'h0);
`endif

    // reset aborts a pending read and clears TX/RX state
    wr(16'h0, 32'h05, 4'h1, RESP_OKAY);
    strobe(8'h09);
    bus.rready = 1'b0;
    bus.araddr = 16'h8; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_rvalid", {31'h0, bus.rvalid}, 0);
    chk("abort_txvalid", {31'h0, tx_valid}, 0);
    bus.rready = 1'b1;
    rd(16'h8, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("r_leftover", exp_r.size(), 0);
    chk("b_leftover", exp_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
